// File: rtl/tns_dec_arbiter_pkg.sv
// Shared constants for the TNS decoder arbiter slice.
// Holds the default geometry and the TNS weight set. TNSnn_A/B/C are the three
// weights of digit group nn (A is the heaviest). TNS_W lists them by codeword bit
// 0..27, so a decoder can sum them in a loop.
package tns_dec_arbiter_pkg;

    localparam int unsigned TNS_CODE_W = 28;
    localparam int unsigned BLEN10_C   = 25;
    localparam int unsigned TNS_DATA_W = BLEN10_C;
    localparam int unsigned DEF_NREQ   = 4;
    localparam int unsigned DEF_ID_W   = 2;

    // Tribonacci-style weights, each one the sum of the three below it.
    localparam int unsigned TNS01_C = 1;
    localparam int unsigned TNS01_B = 2;
    localparam int unsigned TNS01_A = 4;
    localparam int unsigned TNS02_C = 7;
    localparam int unsigned TNS02_B = 13;
    localparam int unsigned TNS02_A = 24;
    localparam int unsigned TNS03_C = 44;
    localparam int unsigned TNS03_B = 81;
    localparam int unsigned TNS03_A = 149;
    localparam int unsigned TNS04_C = 274;
    localparam int unsigned TNS04_B = 504;
    localparam int unsigned TNS04_A = 927;
    localparam int unsigned TNS05_C = 1705;
    localparam int unsigned TNS05_B = 3136;
    localparam int unsigned TNS05_A = 5768;
    localparam int unsigned TNS06_C = 10609;
    localparam int unsigned TNS06_B = 19513;
    localparam int unsigned TNS06_A = 35890;
    localparam int unsigned TNS07_C = 66012;
    localparam int unsigned TNS07_B = 121415;
    localparam int unsigned TNS07_A = 223317;
    localparam int unsigned TNS08_C = 410744;
    localparam int unsigned TNS08_B = 755476;
    localparam int unsigned TNS08_A = 1389537;
    localparam int unsigned TNS09_C = 2555757;
    localparam int unsigned TNS09_B = 4700770;
    localparam int unsigned TNS09_A = 8646064;
    localparam int unsigned TNS10_C = 15902591;

    // Weight of codeword bit b is TNS_W[b].
    localparam int unsigned TNS_W [TNS_CODE_W] = '{
        TNS01_C, TNS01_B, TNS01_A,
        TNS02_C, TNS02_B, TNS02_A,
        TNS03_C, TNS03_B, TNS03_A,
        TNS04_C, TNS04_B, TNS04_A,
        TNS05_C, TNS05_B, TNS05_A,
        TNS06_C, TNS06_B, TNS06_A,
        TNS07_C, TNS07_B, TNS07_A,
        TNS08_C, TNS08_B, TNS08_A,
        TNS09_C, TNS09_B, TNS09_A,
        TNS10_C
    };

endpackage

// File: rtl/tns_dec_arbiter_if.sv
// Request/response bundle between the CAC lanes, the shared decoder and the sink.
//   req_valid/req_code/req_ready : per-lane codeword handshake (lane i at [i*CODE_W +: CODE_W])
//   rsp_valid/rsp_id/rsp_data/rsp_ready : single tagged result channel
//   rsp_err : out-of-range flag, present only when TNS_DEC_OVF_EN is defined
// Modport slave is the arbiter side; master is the lanes plus sink.
interface tns_dec_arbiter_if
    import tns_dec_arbiter_pkg::*;
#(
    parameter int unsigned NREQ   = DEF_NREQ,
    parameter int unsigned CODE_W = TNS_CODE_W,
    parameter int unsigned DATA_W = TNS_DATA_W,
    parameter int unsigned ID_W   = DEF_ID_W
) ();

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*CODE_W-1:0] req_code;
    logic [NREQ-1:0]        req_ready;
    logic                   rsp_valid;
    logic [ID_W-1:0]        rsp_id;
    logic [DATA_W-1:0]      rsp_data;
    logic                   rsp_ready;
`ifdef TNS_DEC_OVF_EN
    logic                   rsp_err;
`endif

    modport slave (
        input  req_valid, req_code, rsp_ready,
`ifdef TNS_DEC_OVF_EN
        output rsp_err,
`endif
        output req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport master (
        output req_valid, req_code, rsp_ready,
`ifdef TNS_DEC_OVF_EN
        input  rsp_err,
`endif
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

endinterface

// File: rtl/tns_dec_arbiter_core.sv
// tns_dec_core: combinational TNS codeword to binary sum.
//   code  : CODE_W-bit TNS codeword
//   sum_c : DATA_W+1-bit weighted sum; the top bit flags an out-of-range codeword
module tns_dec_core
    import tns_dec_arbiter_pkg::*;
#(
    parameter int unsigned CODE_W = TNS_CODE_W,
    parameter int unsigned DATA_W = TNS_DATA_W
) (
    input  logic [CODE_W-1:0] code,
    output logic [DATA_W:0]   sum_c
);

    // Add the weight of every set bit.
    always_comb begin
        sum_c = '0;
        for (int b = 0; b < int'(CODE_W); b++) begin
            if (code[b]) begin
                sum_c = sum_c + (DATA_W+1)'(TNS_W[b]);
            end
        end
    end

endmodule

// File: rtl/tns_dec_arbiter.sv
// tns_dec_arbiter: one registered TNS decoder shared round-robin by NREQ lanes.
// Stage 1 captures the granted codeword and its lane; stage 2 holds the decoded,
// lane-tagged result until the sink takes it.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : tns_dec_arbiter_if.slave (lane requests in, tagged results out)
// Optional: define TNS_DEC_OVF_EN to add bus.rsp_err (decode sum overflowed DATA_W bits).
module tns_dec_arbiter
    import tns_dec_arbiter_pkg::*;
#(
    parameter int unsigned NREQ   = DEF_NREQ,
    parameter int unsigned CODE_W = TNS_CODE_W,
    parameter int unsigned DATA_W = TNS_DATA_W,
    parameter int unsigned ID_W   = DEF_ID_W
) (
    input logic             clk,
    input logic             rst_n,
    tns_dec_arbiter_if.slave bus
);

    logic              adv1_c;
    logic              adv2_c;
    logic              hs_c;
    logic              grant_valid_c;
    logic [ID_W-1:0]   grant_id_c;
    logic [ID_W-1:0]   rr_next_c;
    logic [NREQ-1:0]   ready_c;
    logic [CODE_W-1:0] sel_code_c;
    logic [DATA_W:0]   sum_c;

    logic              s1_valid;
    logic [CODE_W-1:0] s1_code;
    logic [ID_W-1:0]   s1_id;
    logic [ID_W-1:0]   rr_ptr;
    logic              rsp_valid;
    logic [ID_W-1:0]   rsp_id;
    logic [DATA_W-1:0] rsp_data;

    // Stage 2 frees when empty or drained; stage 1 can refill when empty or moving on.
    assign adv2_c = ~rsp_valid | bus.rsp_ready;
    assign adv1_c = ~s1_valid | adv2_c;

    // Round-robin search from rr_ptr; walking downward lets the nearest lane win.
    always_comb begin
        int idx;
        idx           = 0;
        grant_valid_c = 1'b0;
        grant_id_c    = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= int'(NREQ)) begin
                idx = idx - int'(NREQ);
            end
            if (bus.req_valid[ID_W'(idx)]) begin
                grant_valid_c = 1'b1;
                grant_id_c    = ID_W'(idx);
            end
        end
    end

    assign hs_c       = grant_valid_c & adv1_c;
    assign sel_code_c = bus.req_code[CODE_W*32'(grant_id_c) +: CODE_W];
    assign rr_next_c  = (32'(grant_id_c) == NREQ - 1) ? '0 : grant_id_c + ID_W'(1);

    always_comb begin
        ready_c = '0;
        if (hs_c) begin
            ready_c[grant_id_c] = 1'b1;
        end
    end

    assign bus.req_ready = ready_c;

    // Stage 1: capture granted codeword, advance the round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_id    <= '0;
            rr_ptr   <= '0;
        end else if (hs_c) begin
            s1_valid <= 1'b1;
            s1_code  <= sel_code_c;
            s1_id    <= grant_id_c;
            rr_ptr   <= rr_next_c;
        end else if (adv2_c) begin
            s1_valid <= 1'b0;
        end
    end

    tns_dec_core #(
        .CODE_W (CODE_W),
        .DATA_W (DATA_W)
    ) u_core (
        .code  (s1_code),
        .sum_c (sum_c)
    );

    // Stage 2: registered result, held while the sink stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else if (s1_valid && adv2_c) begin
            rsp_valid <= 1'b1;
            rsp_id    <= s1_id;
            rsp_data  <= sum_c[DATA_W-1:0];
        end else if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_id    = rsp_id;
    assign bus.rsp_data  = rsp_data;

`ifdef TNS_DEC_OVF_EN
    logic rsp_err;

    // Overflow flag travels with rsp_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err <= 1'b0;
        end else if (s1_valid && adv2_c) begin
            rsp_err <= sum_c[DATA_W];
        end
    end

    assign bus.rsp_err = rsp_err;
`else
    logic unused_ovf;
    assign unused_ovf = sum_c[DATA_W];
`endif

endmodule

// File: tb/tb_tns_dec_arbiter.sv
// Bench for tns_dec_arbiter: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based model of the shared decoder.
module tb_tns_dec_arbiter;

    localparam int NREQ   = 4;
    localparam int CODE_W = 28;
    localparam int DATA_W = 25;
    localparam int ID_W   = 2;

    typedef struct {
        int              id;
        longint unsigned data;
        bit              err;
        bit              vis;
    } item_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tns_dec_arbiter_if #(.NREQ(NREQ), .CODE_W(CODE_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

    tns_dec_arbiter #(.NREQ(NREQ), .CODE_W(CODE_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    longint unsigned wt [CODE_W];
    item_t q [$];
    int ptr     = 0;
    int last_hs = -1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Weights: 1, 2, 4, then each the sum of the previous three.
    function automatic void build_weights();
        wt[0] = 1; wt[1] = 2; wt[2] = 4;
        for (int i = 3; i < CODE_W; i++) wt[i] = wt[i-1] + wt[i-2] + wt[i-3];
    endfunction

    function automatic longint unsigned ref_sum(input logic [CODE_W-1:0] c);
        longint unsigned s = 0;
        for (int b = 0; b < CODE_W; b++) if (c[b]) s += wt[b];
        return s;
    endfunction

    function automatic logic [CODE_W-1:0] rand_code();
        logic [CODE_W-1:0] r;
        r = CODE_W'($urandom);
        case ($urandom_range(0, 7))
            0: r = '1;
            1: r = '0;
            default: ;
        endcase
        return r;
    endfunction

    // One clock: compare at negedge, advance model at posedge, return at posedge+1.
    task automatic cycle();
        int g;
        bit allow, exp_vld, rdy;
        logic [NREQ-1:0] exp_rdy;
        logic [CODE_W-1:0] cg;
        item_t it;
        @(negedge clk);
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (ptr + k) % NREQ;
            if (bus.req_valid[idx] && g < 0) g = idx;
        end
        allow   = (q.size() < 2) || bus.rsp_ready;
        exp_rdy = '0;
        cg      = '0;
        if (g >= 0 && allow) begin
            exp_rdy[g] = 1'b1;
            cg = bus.req_code[g*CODE_W +: CODE_W];
        end
        check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        exp_vld = (q.size() > 0) && q[0].vis;
        check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_vld));
        if (exp_vld) begin
            check("rsp_id", 64'(bus.rsp_id), 64'(q[0].id));
            check("rsp_data", 64'(bus.rsp_data), 64'(q[0].data));
`ifdef TNS_DEC_OVF_EN
            check("rsp_err", 64'(bus.rsp_err), 64'(q[0].err));
`endif
        end
        rdy = bus.rsp_ready;
        @(posedge clk);
        if (exp_vld && rdy) void'(q.pop_front());
        if (q.size() > 0) begin
            it = q.pop_front();
            it.vis = 1'b1;
            q.push_front(it);
        end
        last_hs = -1;
        if (exp_rdy != '0) begin
            longint unsigned s;
            s = ref_sum(cg);
            it.id   = g;
            it.data = s & ((64'd1 << DATA_W) - 1);
            it.err  = s[DATA_W];
            it.vis  = 1'b0;
            q.push_back(it);
            ptr     = (g + 1) % NREQ;
            last_hs = g;
        end
        #1;
    endtask

    task automatic set_code(input int lane, input logic [CODE_W-1:0] c);
        bus.req_code[lane*CODE_W +: CODE_W] = c;
    endtask

    // Keep every lane requesting; the lane just served presents a fresh codeword.
    task automatic drive_all_valid();
        bus.req_valid = '1;
        if (last_hs >= 0) set_code(last_hs, rand_code());
    endtask

    task automatic drive_random();
        for (int i = 0; i < NREQ; i++) begin
            if (!bus.req_valid[i] || i == last_hs) begin
                bus.req_valid[i] = ($urandom_range(0, 2) != 0);
                set_code(i, rand_code());
            end
        end
        bus.rsp_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic model_reset();
        q.delete();
        ptr     = 0;
        last_hs = -1;
    endtask

    // Lone request on lane 2; result must appear two edges after the handshake.
    task automatic single(input logic [CODE_W-1:0] c, input longint unsigned exp_data, input bit exp_err);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b0100;
        set_code(2, c);
        cycle();
        bus.req_valid = '0;
        cycle();
        check("single_valid", 64'(bus.rsp_valid), 64'd1);
        check("single_id", 64'(bus.rsp_id), 64'd2);
        check("single_data", 64'(bus.rsp_data), 64'(exp_data));
`ifdef TNS_DEC_OVF_EN
        check("single_err", 64'(bus.rsp_err), 64'(exp_err));
`else
        if (exp_err) ; // flag not present in this build
`endif
        cycle();
    endtask

    initial begin
        logic [ID_W-1:0] snap_id;
        logic [DATA_W-1:0] snap_data;
        int pulses [NREQ];

        build_weights();
        bus.req_valid = '0;
        bus.req_code  = '0;
        bus.rsp_ready = 1'b0;

        // Reset state.
        #12;
        check("reset_valid", 64'(bus.rsp_valid), 64'd0);
        check("reset_id", 64'(bus.rsp_id), 64'd0);
        check("reset_data", 64'(bus.rsp_data), 64'd0);
        check("reset_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();

        // Model pins and single-lane decodes.
        check("model_top", 64'(ref_sum(28'h8000000)), 64'd15902591);
        check("model_all", 64'(ref_sum(28'hFFFFFFF)), 64'd34850334);
        single(28'h0000000, 0, 1'b0);
        single(28'h8000000, 15902591, 1'b0);
        single(28'h0000001, 1, 1'b0);
        single(28'hFFFFFFF, 1295902, 1'b1);

        // Pointer now at 3: lanes 1 and 3 requesting -> 3 first, then 1.
        bus.req_valid = 4'b1010;
        set_code(1, rand_code());
        set_code(3, rand_code());
        #1;
        check("rr_first", 64'(bus.req_ready), 64'b1000);
        cycle();
        bus.req_valid[3] = 1'b0;
        #1;
        check("rr_second", 64'(bus.req_ready), 64'b0010);
        cycle();
        bus.req_valid = '0;
        repeat (3) cycle();

        // Backpressure: fill the pipe, stall three cycles, then release.
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) set_code(i, rand_code());
        bus.req_valid = '1;
        repeat (3) begin cycle(); drive_all_valid(); end
        snap_id   = bus.rsp_id;
        snap_data = bus.rsp_data;
        repeat (3) begin
            #1;
            check("stall_ready", 64'(bus.req_ready), 64'd0);
            cycle();
            drive_all_valid();
            check("stall_valid", 64'(bus.rsp_valid), 64'd1);
            check("stall_id", 64'(bus.rsp_id), 64'(snap_id));
            check("stall_data", 64'(bus.rsp_data), 64'(snap_data));
        end
        bus.rsp_ready = 1'b1;
        repeat (4) begin cycle(); drive_all_valid(); end

        // Reset with both stages full.
        bus.rsp_ready = 1'b0;
        repeat (3) begin cycle(); drive_all_valid(); end
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(bus.rsp_valid), 64'd0);
        check("midrst_data", 64'(bus.rsp_data), 64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        #1;
        check("post_rst_grant", 64'(bus.req_ready), 64'b0001);

        // Continuous requests on all lanes: strict rotation, one result per cycle.
        for (int i = 0; i < NREQ; i++) pulses[i] = 0;
        for (int n = 0; n < 8; n++) begin
            check("rot_grant", 64'(bus.req_ready), 64'(1 << (n % NREQ)));
            for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) pulses[i]++;
            cycle();
            drive_all_valid();
            #1;
            if (n >= 1) begin
                check("rot_valid", 64'(bus.rsp_valid), 64'd1);
                check("rot_id", 64'(bus.rsp_id), 64'((n - 1) % NREQ));
            end
        end
        for (int i = 0; i < NREQ; i++) check("rot_pulses", 64'(pulses[i]), 64'd2);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            cycle();
            drive_random();
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (4) cycle();
        check("drained", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tns_dec_arbiter.md
Name: tns_dec_arbiter

Overview:
- Shares one registered TNS 28-bit codeword decoder among NREQ requesting bus lanes.
- Arbitration is round-robin. The datapath is a 2-stage pipeline: capture, then decode.
- Results return on a single response channel tagged with the originating lane index.
- Sits between the CAC receive lanes and the binary data sinks. It replaces per-lane decoder instances where area matters.

Parameters:
- NREQ, 4, number of requesting lanes (2..8).
- CODE_W, 28, codeword width; fixed by the TNS weight set.
- DATA_W, `BLEN10_C, decoded binary width (from TNS.vh).
- ID_W, 2, lane-index width; must satisfy 2^ID_W >= NREQ.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-lane codeword valid.
- req_code  in  NREQ*CODE_W  per-lane codeword; lane i occupies bits [i*CODE_W +: CODE_W].
- req_ready  out  NREQ  per-lane accept; one-hot or zero.
- rsp_valid  out  1  decoded result valid.
- rsp_id  out  ID_W  lane index of the result.
- rsp_data  out  DATA_W  decoded value.
- rsp_ready  in  1  sink accept.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer): s1_valid=0, rsp_valid=0, rsp_id=0, rsp_data=0, rr_ptr=0. In-flight items are discarded, not replayed.
- Stall conditions:
  - adv2 = ~rsp_valid | rsp_ready.
  - adv1 = ~s1_valid | adv2.
- Arbitration (combinational):
  - grant = first lane with req_valid set, searching from rr_ptr upward with wrap from NREQ-1 to 0.
  - req_ready[g] = adv1 & req_valid[g] for the granted lane g; all other lanes are 0.
  - req_ready may depend combinationally on req_valid and rsp_ready.
- Handshake on lane g (req_valid[g] & req_ready[g] at an edge):
  - S1 captures s1_code=req_code[g], s1_id=g, s1_valid=1.
  - rr_ptr becomes (g+1) mod NREQ.
  - If no lane handshakes, rr_ptr holds.
- S1 to S2 (edge with s1_valid & adv2): rsp_data=decode(s1_code), rsp_id=s1_id, rsp_valid=1.
- When S1 is not refilled on that edge, s1_valid drops to 0.
- rsp_valid clears on an rsp_ready edge only when S1 is empty.
- Latency: handshake at edge E gives rsp_valid high after edge E+1. Throughput is 1 result/cycle with rsp_ready held high.
- Backpressure:
  - While rsp_valid & ~rsp_ready, rsp_* hold stable.
  - S1 holds; if S1 is full, all req_ready are 0.
  - Nothing is dropped or duplicated.
- Decode: sum over bits b of codein[b]*W[b].
  - W[27]=`TNS10_C, W[26]=`TNS09_A, W[25]=`TNS09_B, W[24]=`TNS09_C, continuing down through W[2]=`TNS01_A, W[1]=`TNS01_B, W[0]=`TNS01_C.
  - Computed in DATA_W+1 bits; rsp_data takes the low DATA_W bits.
- Requester rules:
  - Once req_valid[i] is asserted it stays high with req_code[i] stable until handshake.
  - The block does not check this rule.
- Simultaneous events: an S2 drain and an S1 refill on the same edge are legal and required for full throughput.

Optional Feature:
- Macro: TNS_DEC_OVF_EN.
- Defined:
  - Adds output rsp_err (1 bit), registered and aligned with rsp_data; reset 0.
  - rsp_err=1 when bit DATA_W of the decode sum is set (codeword out of range).
- Undefined:
  - Port absent.
  - rsp_data is the sum truncated modulo 2^DATA_W.
  - No other change.

Decomposition:
- Weight constants stay in TNS.vh. Add a localparam-style weight list there indexed by bit 0..27, so the core uses a loop rather than 28 named terms.
- Sub-module tns_dec_core: purely combinational, CODE_W in, DATA_W+1 sum out. Reusable by lane-dedicated decoders.
- The round-robin grant stays inline; it is not a separate module.

Test Plan:
- Single lane 2, rsp_ready=1:
  - code 28'h0000000 -> rsp_data=0, rsp_id=2, two edges after handshake.
  - code 28'h8000000 -> `TNS10_C.
  - code 28'h0000001 -> `TNS01_C.
- All 4 lanes valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1 with one result per cycle; each req_ready pulses exactly once per 4 cycles.
- rr_ptr=3 with only lanes 1 and 3 valid -> lane 3 granted first, then lane 1.
- rsp_ready=0 for 3 cycles with a full pipe -> rsp_valid/id/data stable and all req_ready=0. On release, 2 queued results drain in order, then acceptance resumes with no loss.
- rst_n pulsed low mid-stream with S1 and S2 full -> rsp_valid=0 and rsp_data=0 immediately; after release the first grant goes to lane 0.
- With TNS_DEC_OVF_EN, code 28'hFFFFFFF -> rsp_err equals the reference-model sum bit DATA_W; a single-bit code gives rsp_err=0.
